// File: rtl/bl_pkg.sv
// Shared definitions for the bootloader host arbiter.
//   OWNER_*  : encodings driven on the arbiter's 'owner' output
//   BYTE_W   : width of every command/response byte lane
//   arb_state_t : arbiter FSM states
//   owner_code(): maps a host index (0/1) to its owner encoding
package bl_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_H0   = 2'b01;
  localparam logic [1:0] OWNER_H1   = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  function automatic logic [1:0] owner_code(input logic host_idx);
    return host_idx ? OWNER_H1 : OWNER_H0;
  endfunction

endpackage

// File: rtl/bootloader_host_arbiter.sv
// Shares one bootloader command/response port between two byte-stream hosts.
// Ownership is granted per command frame (hN_start), command bytes from the
// owner pass straight through to the bootloader, response bytes are routed to
// the most recent owner, and ownership is released when the bootloader
// finishes (bl_busy falls after having been seen) or when no busy is ever seen
// within TIMEOUT cycles of owner inactivity.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   hN_start                      host N begins a command frame (pulse)
//   hN_in_valid/_data/_ready      host N command byte stream
//   hN_out_valid/_data            response byte for host N (pulse)
//   hN_denied                     the other host currently owns the bootloader
//   bl_in_valid/_data/_ready      command byte stream to the bootloader
//   bl_out_valid/_data            response byte stream from the bootloader
//   bl_busy                       bootloader is executing a command
//   owner                         00 none, 01 host0, 10 host1 (registered)
//   timeout_evt                   one-cycle pulse on a forced release
module bootloader_host_arbiter
  import bl_pkg::*;
#(
  parameter int unsigned          TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd1200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h0_start,
  input  logic              h0_in_valid,
  input  logic [BYTE_W-1:0] h0_in_data,
  output logic              h0_in_ready,
  output logic              h0_out_valid,
  output logic [BYTE_W-1:0] h0_out_data,
  output logic              h0_denied,
  input  logic              h1_start,
  input  logic              h1_in_valid,
  input  logic [BYTE_W-1:0] h1_in_data,
  output logic              h1_in_ready,
  output logic              h1_out_valid,
  output logic [BYTE_W-1:0] h1_out_data,
  output logic              h1_denied,
  output logic              bl_in_valid,
  output logic [BYTE_W-1:0] bl_in_data,
  input  logic              bl_in_ready,
  input  logic              bl_out_valid,
  input  logic [BYTE_W-1:0] bl_out_data,
  input  logic              bl_busy,
  output logic [1:0]        owner,
  output logic              timeout_evt
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT - CNT_ONE;

  arb_state_t           state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;  // host index of most recent grant
  logic                 saw_busy_q, saw_busy_d;
  logic [TIMEOUT_W-1:0] count_q, count_d;
  logic                 timeout_evt_q, timeout_evt_d;

  // Per-host views so the routing logic can be written once per host.
  logic [1:0]        h_start;
  logic [1:0]        h_in_valid;
  logic [BYTE_W-1:0] h_in_data [2];
  logic [1:0]        h_in_ready;
  logic [1:0]        h_out_valid;
  logic [BYTE_W-1:0] h_out_data [2];
  logic [1:0]        h_denied;

  assign h_start      = {h1_start, h0_start};
  assign h_in_valid   = {h1_in_valid, h0_in_valid};
  assign h_in_data[0] = h0_in_data;
  assign h_in_data[1] = h1_in_data;

  assign h0_in_ready  = h_in_ready[0];
  assign h1_in_ready  = h_in_ready[1];
  assign h0_out_valid = h_out_valid[0];
  assign h1_out_valid = h_out_valid[1];
  assign h0_out_data  = h_out_data[0];
  assign h1_out_data  = h_out_data[1];
  assign h0_denied    = h_denied[0];
  assign h1_denied    = h_denied[1];

  // While owning, last_owner_q always names the current owner (it is
  // loaded on every grant), so it doubles as the owner's host index.
  // Gating with rst keeps an in-flight byte from leaking out during reset.
  logic owning;
  logic owner_accept;
  logic owner_start;

  assign owning       = (state_q == ST_OWN) && !rst;
  assign owner_accept = owning && h_in_valid[last_owner_q] && bl_in_ready;
  assign owner_start  = owning && h_start[last_owner_q];

  assign bl_in_valid  = owning && h_in_valid[last_owner_q];
  assign bl_in_data   = owning ? h_in_data[last_owner_q] : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_host
    localparam logic HOST_IDX = 1'(gi);
    logic is_owner;
    assign is_owner = (last_owner_q == HOST_IDX);
    // Non-owner bytes are swallowed so a denied host never stalls.
    assign h_in_ready[gi]  = owning && (is_owner ? bl_in_ready : 1'b1);
    assign h_denied[gi]    = owning && !is_owner;
    // Responses follow last_owner even after release so a late final byte
    // still lands at the host that issued the command.
    assign h_out_valid[gi] = !rst && bl_out_valid && is_owner;
    assign h_out_data[gi]  = h_out_valid[gi] ? bl_out_data : '0;
  end

  always_comb begin
    logic grant_idx;
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    saw_busy_d    = saw_busy_q;
    count_d       = count_q;
    timeout_evt_d = 1'b0;
    grant_idx     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (h_start != 2'b00) begin
          // Simultaneous starts alternate: the host that did not own last wins.
          grant_idx    = (h_start == 2'b11) ? ~last_owner_q : h_start[1];
          state_d      = ST_OWN;
          owner_d      = owner_code(grant_idx);
          last_owner_d = grant_idx;
          saw_busy_d   = 1'b0;
          count_d      = '0;
        end
      end
      ST_OWN: begin
        if (saw_busy_q && !bl_busy) begin
          // Command completed; any start this cycle is dropped.
          state_d    = ST_IDLE;
          owner_d    = OWNER_NONE;
          saw_busy_d = 1'b0;
          count_d    = '0;
        end else if (!saw_busy_q && (count_q == TO_LAST)) begin
          state_d       = ST_IDLE;
          owner_d       = OWNER_NONE;
          saw_busy_d    = 1'b0;
          count_d       = '0;
          timeout_evt_d = 1'b1;
        end else begin
          if (bl_busy) begin
            saw_busy_d = 1'b1;
          end
          // Owner restart is only honoured while the bootloader is idle.
          if (owner_accept || (owner_start && !bl_busy)) begin
            count_d = '0;
          end else if (!saw_busy_q) begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWNER_NONE;
      last_owner_q  <= 1'b1;
      saw_busy_q    <= 1'b0;
      count_q       <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      saw_busy_q    <= saw_busy_d;
      count_q       <= count_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign owner       = owner_q;
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_bootloader_host_arbiter.sv
// Self-checking bench for bootloader_host_arbiter: directed scenarios followed
// by randomized traffic, all compared against a host-level ownership model.
module tb_bootloader_host_arbiter;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       h0_start, h0_in_valid, h0_in_ready, h0_out_valid, h0_denied;
  logic [7:0] h0_in_data, h0_out_data;
  logic       h1_start, h1_in_valid, h1_in_ready, h1_out_valid, h1_denied;
  logic [7:0] h1_in_data, h1_out_data;
  logic       bl_in_valid, bl_in_ready, bl_out_valid, bl_busy;
  logic [7:0] bl_in_data, bl_out_data;
  logic [1:0] owner;
  logic       timeout_evt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bootloader_host_arbiter #(.TIMEOUT_W(24), .TIMEOUT(24'd16)) dut (
    .clk(clk), .rst(rst),
    .h0_start(h0_start), .h0_in_valid(h0_in_valid), .h0_in_data(h0_in_data),
    .h0_in_ready(h0_in_ready), .h0_out_valid(h0_out_valid), .h0_out_data(h0_out_data),
    .h0_denied(h0_denied),
    .h1_start(h1_start), .h1_in_valid(h1_in_valid), .h1_in_data(h1_in_data),
    .h1_in_ready(h1_in_ready), .h1_out_valid(h1_out_valid), .h1_out_data(h1_out_data),
    .h1_denied(h1_denied),
    .bl_in_valid(bl_in_valid), .bl_in_data(bl_in_data), .bl_in_ready(bl_in_ready),
    .bl_out_valid(bl_out_valid), .bl_out_data(bl_out_data), .bl_busy(bl_busy),
    .owner(owner), .timeout_evt(timeout_evt)
  );

  // Reference model: who owns (0 none, 1 host0, 2 host1), who owned last,
  // whether the bootloader has gone busy, and how long the owner has idled.
  int m_own  = 0;
  int m_last = 1;
  bit m_saw  = 0;
  int m_idle = 0;
  bit m_evt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    h0_start = 0; h0_in_valid = 0; h0_in_data = 0;
    h1_start = 0; h1_in_valid = 0; h1_in_data = 0;
    bl_in_ready = 0; bl_out_valid = 0; bl_out_data = 0;
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic check_comb();
    int  oi;
    bit  own;
    logic [7:0] odata;
    bit ovalid;
    own   = (m_own != 0) && !rst;
    oi    = m_own - 1;
    ovalid = (oi == 0) ? h0_in_valid : h1_in_valid;
    odata  = (oi == 0) ? h0_in_data : h1_in_data;
    chk("bl_in_valid", bl_in_valid, own && ovalid);
    chk("bl_in_data",  bl_in_data,  own ? odata : 8'h00);
    chk("h0_in_ready", h0_in_ready, own ? ((oi == 0) ? bl_in_ready : 1'b1) : 1'b0);
    chk("h1_in_ready", h1_in_ready, own ? ((oi == 1) ? bl_in_ready : 1'b1) : 1'b0);
    chk("h0_denied",   h0_denied,   own && oi == 1);
    chk("h1_denied",   h1_denied,   own && oi == 0);
    chk("h0_out_valid", h0_out_valid, !rst && bl_out_valid && m_last == 0);
    chk("h1_out_valid", h1_out_valid, !rst && bl_out_valid && m_last == 1);
    chk("h0_out_data", h0_out_data, (!rst && bl_out_valid && m_last == 0) ? bl_out_data : 8'h00);
    chk("h1_out_data", h1_out_data, (!rst && bl_out_valid && m_last == 1) ? bl_out_data : 8'h00);
  endtask

  task automatic model_clock();
    bit ostart, oacc;
    m_evt = 0;
    if (rst) begin
      m_own = 0; m_last = 1; m_saw = 0; m_idle = 0;
    end else if (m_own == 0) begin
      if (h0_start || h1_start) begin
        if (h0_start && h1_start) m_last = 1 - m_last;
        else                      m_last = h0_start ? 0 : 1;
        m_own = m_last + 1; m_saw = 0; m_idle = 0;
      end
    end else if (m_saw && !bl_busy) begin
      m_own = 0; m_saw = 0; m_idle = 0;
    end else if (!m_saw && m_idle == TMO - 1) begin
      m_own = 0; m_idle = 0; m_evt = 1;
    end else begin
      ostart = (m_own == 1) ? h0_start : h1_start;
      oacc   = ((m_own == 1) ? h0_in_valid : h1_in_valid) && bl_in_ready;
      if (oacc || (ostart && !bl_busy)) m_idle = 0;
      else if (!m_saw)                  m_idle++;
      if (bl_busy) m_saw = 1;
    end
  endtask

  // One clock: check comb outputs, advance model at the edge, check registers.
  task automatic cyc();
    #1;
    check_comb();
    @(posedge clk);
    model_clock();
    #1;
    chk("owner", owner, m_own[1:0]);
    chk("timeout_evt", timeout_evt, m_evt);
  endtask

  initial begin
    int k;
    clr_in();
    bl_busy = 0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("reset_owner", owner, 2'b00);

    // 1: host0 grant and two command bytes
    h0_start = 1; cyc(); h0_start = 0;
    chk("t1_owner", owner, 2'b01);
    h0_in_valid = 1; h0_in_data = 8'h42; bl_in_ready = 1; #1;
    chk("t1_byte0", bl_in_data, 8'h42);
    cyc();
    h0_in_data = 8'h10; #1;
    chk("t1_byte1", bl_in_data, 8'h10);
    cyc();
    h0_in_valid = 0;

    // 2: responses, last one coincident with busy falling
    bl_busy = 1; cyc();
    bl_out_valid = 1; bl_out_data = 8'hBC; #1;
    chk("t2_resp0", h0_out_data, 8'hBC);
    cyc();
    bl_out_data = 8'hCF; bl_busy = 0; #1;
    chk("t2_resp1", h0_out_data, 8'hCF);
    chk("t2_h1_quiet", h1_out_valid, 1'b0);
    cyc();
    bl_out_valid = 0;
    chk("t2_release", owner, 2'b00);

    // 3: denied host keeps draining its bytes
    clr_in(); h0_start = 1; cyc(); h0_start = 0;
    h1_start = 1; h1_in_valid = 1; h1_in_data = 8'h55; #1;
    chk("t3_h1_ready", h1_in_ready, 1'b1);
    chk("t3_h1_denied", h1_denied, 1'b1);
    chk("t3_no_fwd", bl_in_valid, 1'b0);
    cyc(); clr_in();
    bl_busy = 1; cyc(); bl_busy = 0; cyc();

    // 4: tie-break alternates
    rst = 1; cyc(); rst = 0;
    h0_start = 1; h1_start = 1; cyc(); clr_in();
    chk("t4_first", owner, 2'b01);
    bl_busy = 1; cyc(); bl_busy = 0; cyc();
    h0_start = 1; h1_start = 1; cyc(); clr_in();
    chk("t4_second", owner, 2'b10);

    // 6: reset mid-command
    bl_busy = 1; h1_in_valid = 1; h1_in_data = 8'h77; bl_in_ready = 1; cyc();
    rst = 1; cyc(); rst = 0; clr_in();
    chk("t6_owner", owner, 2'b00);
    #1;
    chk("t6_denied", h0_denied, 1'b0);
    chk("t6_bl_valid", bl_in_valid, 1'b0);
    cyc();
    bl_busy = 0;

    // 5: no-response timeout
    h0_start = 1; cyc(); h0_start = 0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (timeout_evt === 1'b1) begin k = i; break; end
    end
    chk("t5_latency", k, TMO);
    chk("t5_owner", owner, 2'b00);
    cyc();
    chk("t5_pulse", timeout_evt, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      h0_start     = ($urandom_range(0, 11) == 0);
      h1_start     = ($urandom_range(0, 11) == 0);
      h0_in_valid  = $urandom_range(0, 1);
      h1_in_valid  = $urandom_range(0, 1);
      h0_in_data   = 8'($urandom);
      h1_in_data   = 8'($urandom);
      bl_in_ready  = ($urandom_range(0, 3) != 0);
      bl_out_valid = ($urandom_range(0, 3) == 0);
      bl_out_data  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) bl_busy = ~bl_busy;
      rst          = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
